// File: rtl/mul_err_pkg.sv
// Shared definitions for the multiplier error-sweep controller.
// Holds the default operand/accumulator widths and the FSM state encoding.
package mul_err_pkg;

  localparam int unsigned W_DEF     = 8;   // operand width
  localparam int unsigned ACC_W_DEF = 32;  // err_sum width

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

endpackage

// File: rtl/mul_err_acc.sv
// Stage-2 error accumulator: absolute difference of the staged products and
// running statistics (nonzero count, saturating sum, first maximum + operands).
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_clear          zero all statistics (sweep restart)
//   i_valid          staged sample is a real sweep point
//   i_exact/i_approx staged products
//   i_c/i_d          staged operands
//   o_err_count, o_err_sum, o_err_max, o_max_c, o_max_d  statistics
module mul_err_acc
  import mul_err_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [2*W-1:0]     i_exact,
  input  logic [2*W-1:0]     i_approx,
  input  logic [W-1:0]       i_c,
  input  logic [W-1:0]       i_d,
  output logic [2*W:0]       o_err_count,
  output logic [ACC_W-1:0]   o_err_sum,
  output logic [2*W-1:0]     o_err_max,
  output logic [W-1:0]       o_max_c,
  output logic [W-1:0]       o_max_d
);

  localparam int unsigned PW   = 2 * W;
  // One bit wider than the larger operand so the add can never wrap before clamping.
  localparam int unsigned SumW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [ACC_W-1:0] AccMax = '1;

  logic [PW:0]        r_count;
  logic [ACC_W-1:0]   r_sum;
  logic [PW-1:0]      r_max;
  logic [W-1:0]       r_max_c;
  logic [W-1:0]       r_max_d;

  logic signed [PW:0] w_diff;
  logic [PW:0]        w_neg;
  logic [PW-1:0]      w_abs;
  logic [SumW-1:0]    w_sum_ext;
  logic               w_sat;

  always_comb begin
    w_diff    = $signed({1'b0, i_exact}) - $signed({1'b0, i_approx});
    w_neg     = -w_diff;
    w_abs     = w_diff[PW] ? w_neg[PW-1:0] : w_diff[PW-1:0];
    w_sum_ext = SumW'(r_sum) + SumW'(w_abs);
    w_sat     = (w_sum_ext > SumW'(AccMax));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_count <= '0;
      r_sum   <= '0;
      r_max   <= '0;
      r_max_c <= '0;
      r_max_d <= '0;
    end else if (i_valid) begin
      if (w_abs != '0) begin
        r_count <= r_count + {{PW{1'b0}}, 1'b1};
      end
      r_sum <= w_sat ? AccMax : w_sum_ext[ACC_W-1:0];
      // Strict compare: ties keep the earliest pair.
      if (w_abs > r_max) begin
        r_max   <= w_abs;
        r_max_c <= i_c;
        r_max_d <= i_d;
      end
    end
  end

  assign o_err_count = r_count;
  assign o_err_sum   = r_sum;
  assign o_err_max   = r_max;
  assign o_max_c     = r_max_c;
  assign o_max_d     = r_max_d;

endmodule

// File: rtl/mul_err_sweep_ctrl.sv
// Sweep controller for on-chip error analysis of approximate multipliers.
// Walks every (c,d) pair through external exact/approximate multipliers,
// stages both products, and feeds the error accumulator.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                sweep request (honoured in IDLE/DONE only)
//   c_o, d_o             operands to both multipliers
//   exact_i, approx_i    combinational products of (c_o,d_o)
//   busy, done           status (RUN/DRAIN, DONE)
//   err_count, err_sum, err_max, max_c, max_d   statistics
module mul_err_sweep_ctrl
  import mul_err_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [W-1:0]       c_o,
  output logic [W-1:0]       d_o,
  input  logic [2*W-1:0]     exact_i,
  input  logic [2*W-1:0]     approx_i,
  output logic               busy,
  output logic               done,
  output logic [2*W:0]       err_count,
  output logic [ACC_W-1:0]   err_sum,
  output logic [2*W-1:0]     err_max,
  output logic [W-1:0]       max_c,
  output logic [W-1:0]       max_d
);

  state_e           r_state;
  logic [2*W-1:0]   r_cnt;
  logic             r_busy;
  logic             r_done;

  // Stage-1 pipeline registers.
  logic             r_valid;
  logic [2*W-1:0]   r_exact;
  logic [2*W-1:0]   r_approx;
  logic [W-1:0]     r_c;
  logic [W-1:0]     r_d;

  logic             w_clear;

  assign w_clear = start && ((r_state == StIdle) || (r_state == StDone));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_exact  <= '0;
      r_approx <= '0;
      r_c      <= '0;
      r_d      <= '0;
    end else begin
      r_valid  <= (r_state == StRun);
      r_exact  <= exact_i;
      r_approx <= approx_i;
      r_c      <= c_o;
      r_d      <= d_o;
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state <= StRun;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        StRun: begin
          // The counter wraps to zero on the last pair, so it is zero outside RUN.
          r_cnt <= r_cnt + {{(2*W-1){1'b0}}, 1'b1};
          if (r_cnt == '1) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          r_state <= StDone;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign c_o  = r_cnt[2*W-1:W];
  assign d_o  = r_cnt[W-1:0];
  assign busy = r_busy;
  assign done = r_done;

  mul_err_acc #(
    .W     (W),
    .ACC_W (ACC_W)
  ) u_acc (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clear     (w_clear),
    .i_valid     (r_valid),
    .i_exact     (r_exact),
    .i_approx    (r_approx),
    .i_c         (r_c),
    .i_d         (r_d),
    .o_err_count (err_count),
    .o_err_sum   (err_sum),
    .o_err_max   (err_max),
    .o_max_c     (max_c),
    .o_max_d     (max_d)
  );

endmodule

// File: doc/mul_err_sweep_ctrl.md
Name: mul_err_sweep_ctrl

Overview:
Hardware sweep controller for on-FPGA error analysis of the approximate multipliers (exact 8x8 vs SCDM8 variants). On a start pulse it walks every operand pair (c,d) through one externally instantiated exact multiplier and one approximate multiplier. It registers both products and accumulates error statistics: nonzero-error count, saturating sum of absolute error, and maximum error with its operands. The results can be read by the PicoSoC through a register wrapper, replacing the file-dump simulation flow for silicon runs.

Parameters:
W, 8, operand width; sweep length N = 2^(2W)
ACC_W, 32, err_sum width; saturates

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
start  input  1  sweep request; sampled only in IDLE or DONE
c_o  output  W  operand c to both multipliers (counter high half)
d_o  output  W  operand d to both multipliers (counter low half)
exact_i  input  2W  exact product of (c_o,d_o), combinational
approx_i  input  2W  approximate product of (c_o,d_o), combinational
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE, held until next start or reset
err_count  output  2W+1  number of pairs with nonzero error
err_sum  output  ACC_W  sum of |exact-approx|, saturating at all-ones
err_max  output  2W  largest |exact-approx|
max_c  output  W  c of first pair reaching err_max
max_d  output  W  d of first pair reaching err_max

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, synchronous and active-low. When rst_n=0 at an edge: state IDLE, sweep counter 0, pipe valid 0, and every output 0 (c_o, d_o, busy, done, err_*, max_c, max_d).
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE, start=1: clear counter, err_count, err_sum, err_max, max_c, max_d, and done; next state RUN.
  - RUN: c_o/d_o = counter[2W-1:W] / counter[W-1:0]. Counter increments each cycle. In the cycle with counter = N-1, next state DRAIN and the counter wraps to 0.
  - DRAIN: exactly one cycle; the final sample is accumulated; next state DONE.
  - DONE: statistics stable; c_o = d_o = 0.
- c_o = d_o = 0 in IDLE, DRAIN and DONE.
- start is ignored in RUN and DRAIN.
- Pipeline:
  - Stage 1 registers exact_i, approx_i, c_o, d_o and valid (=RUN) at the end of the issue cycle.
  - Stage 2 computes the absolute difference using a 2W+1-bit signed subtraction, magnitude 2W bits. When valid, it updates the accumulators at the next edge.
  - Latency from issue to accumulator update: 2 edges.
- Cycle count: start seen at edge 0; done=1 after edge N+1 (N RUN cycles + 1 DRAIN).
- Update rules, when valid and error e:
  - e != 0: err_count += 1.
  - err_sum += e, clamped to 2^ACC_W - 1. It never wraps.
  - e > err_max (strict): err_max = e, max_c/max_d = staged operands. Ties keep the earliest pair.
- Reset mid-sweep: abandons the sweep; all outputs 0 on the next cycle. Partial results are not preserved.
- A restart from DONE clears the previous statistics on the same edge that enters RUN.

Decomposition:
- Shared package/header mul_err_pkg: state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3) and the default W/ACC_W localparams.
- One sub-module, mul_err_acc: the stage-2 abs-difference plus count/sum/max accumulators, with a clear input and a valid input.
- The controller holds the FSM, sweep counter and stage-1 registers.
- Multipliers stay outside; the bench or top level wires S_Exact8/SCDM8_xx to c_o/d_o.

Test Plan:
- approx_i tied to exact model, W=8, start pulse -> done rises 65537 cycles after the start edge; err_count=0, err_sum=0, err_max=0, max_c=max_d=0.
- approx_i = exact with bit0 cleared -> err_count=16384, err_sum=16384, err_max=1, max_c=1, max_d=1.
- approx_i=0 -> err_count=65025, err_sum=1065369600, err_max=65025, max_c=255, max_d=255.
- ACC_W=20, approx_i=0 -> err_sum=0xFFFFF (saturated); err_count and err_max as previous scenario.
- rst_n=0 for one cycle at RUN cycle 1000 -> next cycle busy=0, done=0, all statistics 0; new start -> results identical to the approx_i=0 case.
- start pulsed at RUN cycle 500 -> ignored, done timing unchanged. Then start in DONE -> done=0 and busy=1 next cycle, statistics cleared, sweep repeats with identical final values.
